boot_sequencer: RTL and testbench
=================================

Name: boot_sequencer

Overview:
- Power-up and exit controller for the USB bootloader top level.
- Holds the bootloader core in reset until the 48 MHz PLL has been locked and stable for a settle period, then enables the USB pull-up.
- Watches for USB activity. On a host-less timeout or an explicit boot request, it detaches from the bus, waits, then pulses the iCE40 warmboot primitive with a selected image index.
- Sits between the PLL/warmboot primitives and the bootloader core.

Parameters:
- SETTLE_CYCLES, 4800, cycles of stable pll_lock required before leaving reset (100 us at 48 MHz).
- TIMEOUT_CYCLES, 96000000, cycles in ACTIVE with no USB activity before auto-boot (2 s). 0 disables the timeout.
- DETACH_CYCLES, 480000, cycles with pull-up removed before warmboot (10 ms).
- PULSE_CYCLES, 4, width of the warmboot_boot pulse in cycles. Minimum 1.
- TIMEOUT_IMAGE, 2'b01, image index used for timeout-triggered boot.
- CNT_W, 32, width of the shared cycle counter. Must hold the largest cycle parameter.

Ports:
- clk_48mhz  in  1  system clock, output of the PLL.
- reset  in  1  asynchronous, active-high reset.
- pll_lock  in  1  PLL lock indicator. Synchronised internally with 2 flops.
- usb_activity  in  1  single-cycle pulse per valid USB packet or bus reset seen by the core.
- boot_req  in  1  level or pulse from the core requesting exit to user image. Sampled in ACTIVE only.
- boot_image  in  2  image index, captured in the cycle boot_req is accepted.
- core_reset  out  1  reset to the bootloader core, active-high.
- usb_pu  out  1  USB D+ pull-up enable.
- warmboot_boot  out  1  BOOT input of the warmboot primitive.
- warmboot_s  out  2  {S1,S0} of the warmboot primitive.
- state  out  3  current state encoding, for debug/LED.

Behaviour:
- All outputs are registered.
- Reset values (asynchronous): state=WAIT_LOCK(0), counter=0, core_reset=1, usb_pu=0, warmboot_boot=0, warmboot_s=2'b00, image latch=0, enumerated flag=0.
- Single counter, cleared on every state transition. It increments by 1 per cycle within a state and never wraps; parameters are sized so it cannot.
- lock_s denotes the synchronised pll_lock. It lags pll_lock by 2 cycles.
- States and transitions:
  - WAIT_LOCK(0): core_reset=1, usb_pu=0. Go to SETTLE when lock_s=1.
  - SETTLE(1): core_reset=1, usb_pu=0.
    - If lock_s drops, go to WAIT_LOCK.
    - When counter==SETTLE_CYCLES-1 with lock_s=1, go to ACTIVE.
    - core_reset falls and usb_pu rises on the first ACTIVE cycle.
  - ACTIVE(2): core_reset=0, usb_pu=1.
    - usb_activity clears the counter and sets the enumerated flag.
    - Once enumerated, the timeout is disabled until reset.
    - boot_req=1: latch boot_image, then go to DETACH.
    - Timeout: TIMEOUT_CYCLES!=0, not enumerated, counter==TIMEOUT_CYCLES-1. Latch TIMEOUT_IMAGE, then go to DETACH.
    - lock_s=0: go to WAIT_LOCK. Asserts core_reset, drops usb_pu, clears the enumerated flag.
  - DETACH(3): core_reset=1, usb_pu=0. When counter==DETACH_CYCLES-1, go to BOOT. pll_lock is ignored from here on.
  - BOOT(4): warmboot_s=latched image, driven from the first BOOT cycle and held thereafter. warmboot_boot=1 for exactly PULSE_CYCLES cycles, then go to HALT.
  - HALT(5): core_reset=1, usb_pu=0, warmboot_boot=0, warmboot_s held. Only reset exits this state.
- Priorities within ACTIVE, same cycle:
  - lock_s loss beats boot_req.
  - boot_req beats the timeout.
  - usb_activity beats the timeout, so no boot occurs and the counter is cleared.
- boot_req outside ACTIVE is ignored and not remembered.
- Reset asserted in any state, including mid-pulse in BOOT, returns all outputs to their reset values immediately (asynchronous).
- Unused encodings 6 and 7 go to WAIT_LOCK on the next clock.

Test Plan:
- Bench parameters: SETTLE=8, TIMEOUT=50, DETACH=20, PULSE=4, TIMEOUT_IMAGE=2'b01.
- Power-up: release reset, pll_lock=1 at cycle 0.
  - ACTIVE entered after 2 sync cycles + 8 settle cycles.
  - core_reset=0 and usb_pu=1 from that cycle.
  - warmboot_boot stays 0.
- Lock glitch: pll_lock low for 3 cycles at SETTLE count 5 → return to WAIT_LOCK. A full 8-cycle settle is required after relock.
- Timeout boot, no usb_activity:
  - 50 cycles in ACTIVE → DETACH, usb_pu=0.
  - 20 cycles later, warmboot_s=2'b01 and warmboot_boot=1 for exactly 4 cycles.
  - Then HALT, with state=5 held.
- Activity keeps alive: usb_activity at ACTIVE cycle 49, then idle 200 cycles → no DETACH. Then boot_req with boot_image=2'b10 → warmboot_s=2'b10 and a 4-cycle pulse after 20 detach cycles.
- Same-cycle: boot_req with boot_image=2'b11 on the timeout cycle → image 2'b11 latched.
- Reset mid-operation: reset at BOOT pulse cycle 2 → warmboot_boot=0, core_reset=1, state=0 asynchronously.

Source files
------------

// File: rtl/boot_sequencer.sv
// Power-up and exit controller for the USB bootloader: gates the core out of reset once the PLL
// is stably locked, then detaches from USB and fires the iCE40 warmboot pulse on request or timeout.
module boot_sequencer #(
  parameter int unsigned SETTLE_CYCLES  = 4800,
  parameter int unsigned TIMEOUT_CYCLES = 96000000,
  parameter int unsigned DETACH_CYCLES  = 480000,
  parameter int unsigned PULSE_CYCLES   = 4,
  parameter logic [1:0]  TIMEOUT_IMAGE  = 2'b01,
  parameter int unsigned CNT_W          = 32
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       usb_activity,
  input  logic       boot_req,
  input  logic [1:0] boot_image,
  output logic       core_reset,
  output logic       usb_pu,
  output logic       warmboot_boot,
  output logic [1:0] warmboot_s,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_SETTLE    = 3'd1,
    S_ACTIVE    = 3'd2,
    S_DETACH    = 3'd3,
    S_BOOT      = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DETACH_LAST  = CNT_W'(DETACH_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_CYCLES - 1);

  logic [1:0]       sync_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       image_q, image_d;
  logic             enum_q, enum_d;
  logic             core_reset_q, usb_pu_q, wb_boot_q;
  logic [1:0]       wb_s_q;
  logic             lock_s;

  assign lock_s = sync_q[1];

  // Next-state logic; the shared counter restarts on every state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    image_d = image_q;
    enum_d  = enum_q;
    case (state_q)
      S_WAIT_LOCK: if (lock_s) state_d = S_SETTLE;
      S_SETTLE: begin
        if (!lock_s)                   state_d = S_WAIT_LOCK;
        else if (cnt_q == SETTLE_LAST) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
          enum_d  = 1'b0;
        end else if (boot_req) begin
          image_d = boot_image;
          state_d = S_DETACH;
        end else if (usb_activity) begin
          cnt_d  = '0;
          enum_d = 1'b1;
        end else if (TIMEOUT_CYCLES != 0 && !enum_q && cnt_q == TIMEOUT_LAST) begin
          image_d = TIMEOUT_IMAGE;
          state_d = S_DETACH;
        end
      end
      S_DETACH: if (cnt_q == DETACH_LAST) state_d = S_BOOT;
      S_BOOT:   if (cnt_q == PULSE_LAST)  state_d = S_HALT;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_WAIT_LOCK;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Outputs are decoded from the next state so they change on the transition edge itself.
  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      sync_q       <= 2'b00;
      state_q      <= S_WAIT_LOCK;
      cnt_q        <= '0;
      image_q      <= 2'b00;
      enum_q       <= 1'b0;
      core_reset_q <= 1'b1;
      usb_pu_q     <= 1'b0;
      wb_boot_q    <= 1'b0;
      wb_s_q       <= 2'b00;
    end else begin
      sync_q       <= {sync_q[0], pll_lock};
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      image_q      <= image_d;
      enum_q       <= enum_d;
      core_reset_q <= (state_d != S_ACTIVE);
      usb_pu_q     <= (state_d == S_ACTIVE);
      wb_boot_q    <= (state_d == S_BOOT);
      if (state_d == S_BOOT) wb_s_q <= image_d;
    end
  end

  assign core_reset    = core_reset_q;
  assign usb_pu        = usb_pu_q;
  assign warmboot_boot = wb_boot_q;
  assign warmboot_s    = wb_s_q;
  assign state         = state_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// Self-checking bench for boot_sequencer: per-scenario vector tables feed a scoreboard queue,
// plus a hand-written asynchronous reset in the middle of the warmboot pulse.
module tb_boot_sequencer;

  localparam int unsigned SETTLE  = 8;
  localparam int unsigned TIMEOUT = 50;
  localparam int unsigned DETACH  = 20;
  localparam int unsigned PULSE   = 4;

  logic       clk_48mhz = 1'b0;
  logic       reset;
  logic       pll_lock, usb_activity, boot_req;
  logic [1:0] boot_image;
  logic       core_reset, usb_pu, warmboot_boot;
  logic [1:0] warmboot_s;
  logic [2:0] state;

  always #5 clk_48mhz = ~clk_48mhz;

  boot_sequencer #(
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TIMEOUT),
    .DETACH_CYCLES (DETACH),
    .PULSE_CYCLES  (PULSE),
    .TIMEOUT_IMAGE (2'b01),
    .CNT_W         (32)
  ) dut (
    .clk_48mhz    (clk_48mhz),
    .reset        (reset),
    .pll_lock     (pll_lock),
    .usb_activity (usb_activity),
    .boot_req     (boot_req),
    .boot_image   (boot_image),
    .core_reset   (core_reset),
    .usb_pu       (usb_pu),
    .warmboot_boot(warmboot_boot),
    .warmboot_s   (warmboot_s),
    .state        (state)
  );

  // One row: inputs sampled at edge cyc, expected outputs just after that edge when chk=1.
  typedef struct {
    int unsigned cyc;
    logic        lock;
    logic        act;
    logic        req;
    logic [1:0]  img;
    logic        chk;
    logic [2:0]  st;
    logic [1:0]  ws;
  } vec_t;

  typedef struct {
    int unsigned cyc;
    logic [2:0]  st;
    logic        crst;
    logic        pu;
    logic        wb;
    logic [1:0]  ws;
  } exp_t;

  vec_t  tbl[$];
  exp_t  sb_q[$];
  int    checks = 0;
  int    errors = 0;
  string scen;

  function automatic vec_t v(int unsigned cyc, logic lock, logic act, logic req,
                             logic [1:0] img, logic chk, logic [2:0] st, logic [1:0] ws);
    vec_t r;
    r.cyc = cyc; r.lock = lock; r.act = act; r.req = req; r.img = img;
    r.chk = chk; r.st = st; r.ws = ws;
    return r;
  endfunction

  // Output values the design must show in each state.
  function automatic exp_t exp_for(int unsigned cyc, logic [2:0] st, logic [1:0] ws);
    exp_t e;
    e.cyc  = cyc;
    e.st   = st;
    e.crst = (st != 3'd2);
    e.pu   = (st == 3'd2);
    e.wb   = (st == 3'd4);
    e.ws   = ws;
    return e;
  endfunction

  task automatic check_pop();
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard underflow", scen);
      return;
    end
    e = sb_q.pop_front();
    if (state !== e.st || core_reset !== e.crst || usb_pu !== e.pu ||
        warmboot_boot !== e.wb || warmboot_s !== e.ws) begin
      errors++;
      $display("FAIL %s cyc %0d: got st=%0d crst=%b pu=%b wb=%b ws=%b, expected st=%0d crst=%b pu=%b wb=%b ws=%b",
               scen, e.cyc, state, core_reset, usb_pu, warmboot_boot, warmboot_s,
               e.st, e.crst, e.pu, e.wb, e.ws);
    end
  endtask

  task automatic do_reset(string nm);
    scen         = nm;
    reset        = 1'b1;
    pll_lock     = 1'b0;
    usb_activity = 1'b0;
    boot_req     = 1'b0;
    boot_image   = 2'b00;
    @(negedge clk_48mhz);
    @(negedge clk_48mhz);
    sb_q.push_back(exp_for(0, 3'd0, 2'b00));
    check_pop();
    reset = 1'b0;
    tbl.delete();
  endtask

  task automatic run_table();
    int   idx   = 0;
    logic lock_h = 1'b0;
    logic chk;
    int unsigned last = tbl[tbl.size()-1].cyc;
    for (int unsigned c = 1; c <= last; c++) begin
      usb_activity = 1'b0;
      boot_req     = 1'b0;
      boot_image   = 2'b00;
      chk          = 1'b0;
      if (idx < tbl.size() && tbl[idx].cyc == c) begin
        lock_h       = tbl[idx].lock;
        usb_activity = tbl[idx].act;
        boot_req     = tbl[idx].req;
        boot_image   = tbl[idx].img;
        chk          = tbl[idx].chk;
        if (chk) sb_q.push_back(exp_for(c, tbl[idx].st, tbl[idx].ws));
        idx++;
      end
      pll_lock = lock_h;
      @(posedge clk_48mhz);
      #1;
      if (chk) check_pop();
    end
    usb_activity = 1'b0;
    boot_req     = 1'b0;
  endtask

  initial begin
    // Power-up, timeout boot with image 01, lock loss ignored after detach.
    do_reset("timeout");
    tbl.push_back(v(1,   1, 0, 0, 2'b00, 1, 3'd0, 2'b00));
    tbl.push_back(v(2,   1, 0, 0, 2'b00, 1, 3'd0, 2'b00));
    tbl.push_back(v(3,   1, 0, 0, 2'b00, 1, 3'd1, 2'b00));
    tbl.push_back(v(10,  1, 0, 0, 2'b00, 1, 3'd1, 2'b00));
    tbl.push_back(v(11,  1, 0, 0, 2'b00, 1, 3'd2, 2'b00));
    tbl.push_back(v(40,  1, 0, 0, 2'b00, 1, 3'd2, 2'b00));
    tbl.push_back(v(60,  1, 0, 0, 2'b00, 1, 3'd2, 2'b00));
    tbl.push_back(v(61,  1, 0, 0, 2'b00, 1, 3'd3, 2'b00));
    tbl.push_back(v(70,  0, 0, 0, 2'b00, 1, 3'd3, 2'b00));
    tbl.push_back(v(80,  0, 0, 0, 2'b00, 1, 3'd3, 2'b00));
    tbl.push_back(v(81,  0, 0, 0, 2'b00, 1, 3'd4, 2'b01));
    tbl.push_back(v(82,  0, 0, 0, 2'b00, 1, 3'd4, 2'b01));
    tbl.push_back(v(83,  0, 0, 0, 2'b00, 1, 3'd4, 2'b01));
    tbl.push_back(v(84,  0, 0, 0, 2'b00, 1, 3'd4, 2'b01));
    tbl.push_back(v(85,  0, 0, 0, 2'b00, 1, 3'd5, 2'b01));
    tbl.push_back(v(100, 0, 0, 0, 2'b00, 1, 3'd5, 2'b01));
    run_table();

    // Lock glitch in SETTLE, lock loss in ACTIVE beats boot_req, boot_req outside ACTIVE forgotten.
    do_reset("glitch");
    tbl.push_back(v(1,   1, 0, 0, 2'b00, 1, 3'd0, 2'b00));
    tbl.push_back(v(7,   0, 0, 0, 2'b00, 1, 3'd1, 2'b00));
    tbl.push_back(v(8,   0, 0, 0, 2'b00, 1, 3'd1, 2'b00));
    tbl.push_back(v(9,   0, 0, 0, 2'b00, 1, 3'd0, 2'b00));
    tbl.push_back(v(10,  1, 0, 0, 2'b00, 1, 3'd0, 2'b00));
    tbl.push_back(v(11,  1, 0, 0, 2'b00, 1, 3'd0, 2'b00));
    tbl.push_back(v(12,  1, 0, 0, 2'b00, 1, 3'd1, 2'b00));
    tbl.push_back(v(19,  1, 0, 0, 2'b00, 1, 3'd1, 2'b00));
    tbl.push_back(v(20,  1, 0, 0, 2'b00, 1, 3'd2, 2'b00));
    tbl.push_back(v(25,  0, 0, 0, 2'b00, 1, 3'd2, 2'b00));
    tbl.push_back(v(26,  0, 0, 0, 2'b00, 1, 3'd2, 2'b00));
    tbl.push_back(v(27,  0, 0, 1, 2'b10, 1, 3'd0, 2'b00));
    tbl.push_back(v(30,  1, 0, 0, 2'b00, 1, 3'd0, 2'b00));
    tbl.push_back(v(31,  1, 0, 0, 2'b00, 1, 3'd0, 2'b00));
    tbl.push_back(v(32,  1, 0, 0, 2'b00, 1, 3'd1, 2'b00));
    tbl.push_back(v(35,  1, 0, 1, 2'b10, 1, 3'd1, 2'b00));
    tbl.push_back(v(39,  1, 0, 0, 2'b00, 1, 3'd1, 2'b00));
    tbl.push_back(v(40,  1, 0, 0, 2'b00, 1, 3'd2, 2'b00));
    tbl.push_back(v(89,  1, 0, 0, 2'b00, 1, 3'd2, 2'b00));
    tbl.push_back(v(90,  1, 0, 0, 2'b00, 1, 3'd3, 2'b00));
    tbl.push_back(v(109, 1, 0, 0, 2'b00, 1, 3'd3, 2'b00));
    tbl.push_back(v(110, 1, 0, 0, 2'b00, 1, 3'd4, 2'b01));
    run_table();

    // Activity on the would-be timeout cycle disables the timeout; later boot_req selects image 10.
    do_reset("activity");
    tbl.push_back(v(1,   1, 0, 0, 2'b00, 1, 3'd0, 2'b00));
    tbl.push_back(v(11,  1, 0, 0, 2'b00, 1, 3'd2, 2'b00));
    tbl.push_back(v(60,  1, 0, 0, 2'b00, 1, 3'd2, 2'b00));
    tbl.push_back(v(61,  1, 1, 0, 2'b00, 1, 3'd2, 2'b00));
    tbl.push_back(v(110, 1, 0, 0, 2'b00, 1, 3'd2, 2'b00));
    tbl.push_back(v(111, 1, 0, 0, 2'b00, 1, 3'd2, 2'b00));
    tbl.push_back(v(261, 1, 0, 0, 2'b00, 1, 3'd2, 2'b00));
    tbl.push_back(v(262, 1, 0, 1, 2'b10, 1, 3'd3, 2'b00));
    tbl.push_back(v(281, 1, 0, 0, 2'b00, 1, 3'd3, 2'b00));
    tbl.push_back(v(282, 1, 0, 0, 2'b00, 1, 3'd4, 2'b10));
    tbl.push_back(v(285, 1, 0, 0, 2'b00, 1, 3'd4, 2'b10));
    tbl.push_back(v(286, 1, 0, 0, 2'b00, 1, 3'd5, 2'b10));
    run_table();

    // boot_req on the timeout cycle wins and its image is latched.
    do_reset("same_cycle");
    tbl.push_back(v(1,  1, 0, 0, 2'b00, 1, 3'd0, 2'b00));
    tbl.push_back(v(60, 1, 0, 0, 2'b00, 1, 3'd2, 2'b00));
    tbl.push_back(v(61, 1, 0, 1, 2'b11, 1, 3'd3, 2'b00));
    tbl.push_back(v(80, 1, 0, 0, 2'b00, 1, 3'd3, 2'b00));
    tbl.push_back(v(81, 1, 0, 0, 2'b00, 1, 3'd4, 2'b11));
    tbl.push_back(v(84, 1, 0, 0, 2'b00, 1, 3'd4, 2'b11));
    tbl.push_back(v(85, 1, 0, 0, 2'b00, 1, 3'd5, 2'b11));
    run_table();

    // Asynchronous reset on the second cycle of the warmboot pulse.
    do_reset("mid_pulse");
    tbl.push_back(v(1,  1, 0, 0, 2'b00, 1, 3'd0, 2'b00));
    tbl.push_back(v(81, 1, 0, 0, 2'b00, 1, 3'd4, 2'b01));
    tbl.push_back(v(82, 1, 0, 0, 2'b00, 1, 3'd4, 2'b01));
    run_table();
    #2;
    reset = 1'b1;
    #1;
    sb_q.push_back(exp_for(83, 3'd0, 2'b00));
    check_pop();
    @(posedge clk_48mhz);
    #1;
    sb_q.push_back(exp_for(84, 3'd0, 2'b00));
    check_pop();
    reset = 1'b0;

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
